// File: rtl/mpu_sensor_poller.sv
`default_nettype none
// ============================================================================
// Module   : mpu_sensor_poller
// Brief    : Initialises an MPU-class sensor over an SPI byte engine, checks
//            WHO_AM_I, then periodically reads NUM_CH big-endian 16-bit
//            channels and publishes them atomically with a valid strobe.
// Revision : 1.0 - initial release
// ============================================================================
module mpu_sensor_poller #(
    parameter int         NUM_CH       = 7,
    parameter logic [6:0] BASE_ADDR    = 7'h3B,
    parameter int         PERIOD       = 1000000,
    parameter logic [6:0] WHOAMI_ADDR  = 7'h75,
    parameter logic [7:0] WHOAMI_EXP   = 8'h71,
    parameter logic [6:0] INIT0_ADDR   = 7'h6B,
    parameter logic [7:0] INIT0_DATA   = 8'h00,
    parameter logic [6:0] INIT1_ADDR   = 7'h37,
    parameter logic [7:0] INIT1_DATA   = 8'h02,
    parameter int         BUSY_TIMEOUT = 4096,
    parameter bit         SWAP_BYTES   = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    output logic                  spi_start,
    output logic                  spi_rd_wr_sel,
    output logic [6:0]            spi_addr,
    output logic [7:0]            spi_wr_data,
    input  logic                  spi_busy,
    input  logic [7:0]            spi_rd_data,
    output logic [16*NUM_CH-1:0]  samples,
    output logic                  sample_valid,
    output logic [15:0]           frame_count,
    output logic [7:0]            whoami,
    output logic                  id_error,
    output logic                  timeout_error,
    output logic                  overrun
);

    localparam int c_NBYTES = 2 * NUM_CH;
    localparam int c_IDX_W  = $clog2(c_NBYTES + 1);
    localparam int c_TMR_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int c_TO_W   = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NBYTES - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(PERIOD - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_BOOT    = 3'd0,
        S_INIT0   = 3'd1,
        S_INIT1   = 3'd2,
        S_WHO     = 3'd3,
        S_IDLE    = 3'd4,
        S_READ    = 3'd5,
        S_PUBLISH = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        PH_WAIT  = 2'd0,
        PH_START = 2'd1,
        PH_BUSY  = 2'd2
    } phase_t;

    state_t                 r_state, w_state_nxt;
    phase_t                 r_phase, w_phase_nxt;
    logic [1:0]             r_rst_sync;
    logic [c_IDX_W-1:0]     r_byte_idx;
    logic [c_TO_W-1:0]      r_xfer_cnt;
    logic [c_TMR_W-1:0]     r_timer;
    logic                   r_timer_run;
    logic [16*NUM_CH-1:0]   r_shadow;
    logic [16*NUM_CH-1:0]   r_samples;
    logic                   r_sample_valid;
    logic [15:0]            r_frame_count;
    logic [7:0]             r_whoami;
    logic                   r_id_error;
    logic                   r_timeout_error;
    logic                   r_overrun;

    logic                   w_rst_n;
    logic                   w_in_xfer;
    logic                   w_xfer_done;
    logic                   w_xfer_to;
    logic                   w_tick;
    logic [c_IDX_W-1:0]     w_slot;
    logic [c_IDX_W+2:0]     w_bit_off;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_in_xfer   = r_state inside {S_INIT0, S_INIT1, S_WHO, S_READ};
    assign w_xfer_done = w_in_xfer && (r_phase == PH_BUSY) && !spi_busy;
    assign w_xfer_to   = w_in_xfer && (r_phase != PH_WAIT) && !w_xfer_done &&
                         (r_xfer_cnt == c_TO_LAST);
    assign w_tick      = r_timer_run && (r_timer == c_TMR_LAST);

    // Even byte index is the high byte; SWAP_BYTES flips which half it lands in.
    assign w_slot    = {r_byte_idx[c_IDX_W-1:1], ~r_byte_idx[0] ^ SWAP_BYTES};
    assign w_bit_off = {w_slot, 3'b000};

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_BOOT;
            r_phase <= PH_WAIT;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        spi_start     = w_in_xfer && (r_phase == PH_START);
        spi_rd_wr_sel = 1'b0;
        spi_addr      = 7'h00;
        spi_wr_data   = 8'h00;

        case (r_state)
            S_INIT0: begin spi_addr = INIT0_ADDR; spi_wr_data = INIT0_DATA; end
            S_INIT1: begin spi_addr = INIT1_ADDR; spi_wr_data = INIT1_DATA; end
            S_WHO:   begin spi_addr = WHOAMI_ADDR; spi_rd_wr_sel = 1'b1; end
            S_READ:  begin spi_addr = BASE_ADDR + 7'(r_byte_idx); spi_rd_wr_sel = 1'b1; end
            default: ;
        endcase

        if (w_xfer_to) begin
            w_state_nxt = S_BOOT;
            w_phase_nxt = PH_WAIT;
        end else begin
            case (r_state)
                S_BOOT:    if (!spi_busy) w_state_nxt = S_INIT0;
                S_IDLE:    if (w_tick && enable) w_state_nxt = S_READ;
                S_PUBLISH: w_state_nxt = S_IDLE;
                S_INIT0, S_INIT1, S_WHO, S_READ: begin
                    case (r_phase)
                        PH_WAIT:  if (!spi_busy) w_phase_nxt = PH_START;
                        PH_START: if (spi_busy)  w_phase_nxt = PH_BUSY;
                        PH_BUSY: begin
                            if (!spi_busy) begin
                                w_phase_nxt = PH_WAIT;
                                case (r_state)
                                    S_INIT0: w_state_nxt = S_INIT1;
                                    S_INIT1: w_state_nxt = S_WHO;
                                    S_WHO:   w_state_nxt = S_IDLE;
                                    default: if (r_byte_idx == c_LAST_IDX) w_state_nxt = S_PUBLISH;
                                endcase
                            end
                        end
                        default: w_phase_nxt = PH_WAIT;
                    endcase
                end
                default: w_state_nxt = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_byte_idx      <= '0;
            r_xfer_cnt      <= '0;
            r_timer         <= '0;
            r_timer_run     <= 1'b0;
            r_shadow        <= '0;
            r_samples       <= '0;
            r_sample_valid  <= 1'b0;
            r_frame_count   <= 16'h0000;
            r_whoami        <= 8'h00;
            r_id_error      <= 1'b0;
            r_timeout_error <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;

            if (w_in_xfer && (r_phase != PH_WAIT)) r_xfer_cnt <= r_xfer_cnt + c_TO_W'(1);
            else                                   r_xfer_cnt <= '0;

            // Timeout forces a full re-init, so the period timer restarts after WHO.
            if (w_xfer_to) begin
                r_timer_run     <= 1'b0;
                r_timer         <= '0;
                r_byte_idx      <= '0;
                r_timeout_error <= 1'b1;
            end else if ((r_state == S_WHO) && w_xfer_done) begin
                r_timer_run <= 1'b1;
                r_timer     <= '0;
            end else if (r_timer_run) begin
                r_timer <= w_tick ? '0 : r_timer + c_TMR_W'(1);
            end

            if (w_tick && ((r_state == S_READ) || (r_state == S_PUBLISH)))
                r_overrun <= 1'b1;

            if (w_xfer_done && (r_state == S_WHO)) begin
                r_whoami <= spi_rd_data;
                if (spi_rd_data != WHOAMI_EXP) r_id_error <= 1'b1;
            end

            if (w_xfer_done && (r_state == S_READ)) begin
                r_shadow[w_bit_off +: 8] <= spi_rd_data;
                r_byte_idx <= (r_byte_idx == c_LAST_IDX) ? '0 : r_byte_idx + c_IDX_W'(1);
            end

            if (r_state == S_PUBLISH) begin
                r_samples      <= r_shadow;
                r_sample_valid <= 1'b1;
                r_frame_count  <= r_frame_count + 16'd1;
            end
        end
    end

    assign samples       = r_samples;
    assign sample_valid  = r_sample_valid;
    assign frame_count   = r_frame_count;
    assign whoami        = r_whoami;
    assign id_error      = r_id_error;
    assign timeout_error = r_timeout_error;
    assign overrun       = r_overrun;

endmodule
`default_nettype wire

// File: doc/mpu_sensor_poller.md
Name: mpu_sensor_poller

Overview:
- Parametrised successor to the single-purpose MPU9250 gyro reader.
- Runs the init writes and WHO_AM_I check, then periodically reads NUM_CH contiguous 16-bit big-endian sensor registers through the existing SPI byte engine.
- Publishes all channels atomically with a valid strobe for the ARM-side reader, and adds timeout, ID-check and overrun reporting.

Parameters:
- NUM_CH, 7: channels per frame (1..16); defaults cover accel XYZ, temp and gyro XYZ.
- BASE_ADDR, 7'h3B: register address of channel 0 high byte; channel k high byte = BASE_ADDR+2k, low byte = +1.
- PERIOD, 1000000: clk cycles between frame starts (>= 2).
- WHOAMI_ADDR, 7'h75 / WHOAMI_EXP, 8'h71: ID register and its expected value.
- INIT0_ADDR, 7'h6B / INIT0_DATA, 8'h00; INIT1_ADDR, 7'h37 / INIT1_DATA, 8'h02: the two power-up writes.
- BUSY_TIMEOUT, 4096: max cycles spent waiting on one SPI transaction.
- SWAP_BYTES, 0: 1 = assemble {low,high} instead of {high,low}.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  1 = run periodic frames; 0 = finish current frame, then hold in IDLE
- spi_start  out  1  transaction request to SPI byte engine
- spi_rd_wr_sel  out  1  1 = read, 0 = write
- spi_addr  out  7  register address
- spi_wr_data  out  8  write byte
- spi_busy  in  1  engine busy
- spi_rd_data  in  8  byte returned by last read
- samples  out  16*NUM_CH  channel k at [16k+15:16k]
- sample_valid  out  1  one-cycle pulse when samples update
- frame_count  out  16  frames published, wraps 16'hFFFF->0
- whoami  out  8  captured ID byte
- id_error  out  1  sticky: whoami != WHOAMI_EXP
- timeout_error  out  1  sticky: a transaction exceeded BUSY_TIMEOUT
- overrun  out  1  sticky: period tick arrived while a frame was in progress

Behaviour:
- Reset (async assert, sync release): all outputs 0, state BOOT, timers cleared. Sticky flags clear only on reset.
- Transaction primitive XFER, used by every access:
  - Wait for spi_busy==0, then drive addr/data/sel and assert spi_start.
  - Hold spi_start until spi_busy==1 is sampled, drop it, then wait for spi_busy==0.
  - Read data is captured the cycle after spi_busy falls.
  - A per-transaction cycle counter runs from start assertion. Reaching BUSY_TIMEOUT sets timeout_error, drops spi_start and returns to BOOT (full re-init).
- States:
  - BOOT: wait spi_busy==0.
  - INIT0 -> INIT1: XFER writes.
  - WHO: XFER read; whoami <= byte; id_error set on mismatch. Polling proceeds regardless.
  - IDLE.
  - READ: byte index b = 0 .. 2*NUM_CH-1, address BASE_ADDR+b. Bytes are held in a shadow register; samples are not touched.
  - PUBLISH: samples <= shadow in one cycle; sample_valid=1 for that cycle; frame_count++. Then IDLE.
- Period timer:
  - Free-running 0..PERIOD-1 once WHO completes; tick at PERIOD-1.
  - Tick in IDLE with enable=1 -> READ on the next cycle.
  - Tick during READ/PUBLISH -> set overrun and drop the tick (no queued frame).
  - Tick with enable=0 is ignored.
- enable falling mid-frame: the frame completes and publishes.
- Latency, tick to sample_valid = 2*NUM_CH*(XFER time) + 2 cycles.
- Byte assembly: {high,low} unless SWAP_BYTES=1. samples are stable between sample_valid pulses; a partially read frame is never visible.
- Reset mid-transaction: spi_start drops immediately; after release the sequence restarts from BOOT.

Test Plan:
- Behavioural SPI model, busy 20 cycles, ID 0x71, NUM_CH=7, PERIOD=2000 -> writes 0x6B<=0x00 then 0x37<=0x02, one read of 0x75, whoami=0x71, id_error=0, first frame reads 0x3B..0x48 in order.
- Model returns byte = address (0x3B,0x3C,...) -> samples ch0=16'h3B3C, ch6=16'h4748. With SWAP_BYTES=1, ch0=16'h3C3B.
- ID returned 0x70 -> id_error=1 and stays 1; frames still publish; sample_valid pulses every 2000 cycles, exactly one cycle wide.
- Model holds busy high forever on the 3rd transaction, BUSY_TIMEOUT=64 -> timeout_error=1 within 64 cycles of start, then re-init from INIT0 after busy released.
- PERIOD=100 with busy 20 cycles (frame longer than period) -> overrun=1; no frame is skipped mid-read; samples never show mixed old/new bytes.
- enable deasserted mid-frame, then reset_n pulsed low during a READ transaction -> current frame publishes (frame_count+1); on reset all outputs 0, spi_start low in the same cycle, clean restart.
